// File: rtl/multicycle_controller.sv
// Main control FSM and ALU decoder for the multi-cycle MIPS datapath.
// Optional bne support is enabled by defining MC_BNE_EN.
module multicycle_controller #(
    parameter int unsigned STATE_W   = 4,
    parameter int unsigned FETCH_ENC = 0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [5:0]         op,
    input  logic [5:0]         funct,
    input  logic               zero,
    output logic               pcen,
    output logic               memwrite,
    output logic               irwrite,
    output logic               regwrite,
    output logic               iord,
    output logic               memtoreg,
    output logic               regdst,
    output logic               alusrca,
    output logic [1:0]         alusrcb,
    output logic [1:0]         pcsrc,
    output logic [2:0]         alucontrol,
    output logic               instr_done,
    output logic [STATE_W-1:0] state
);

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FN_ADD   = 6'b100000;
    localparam logic [5:0] FN_SUB   = 6'b100010;
    localparam logic [5:0] FN_AND   = 6'b100100;
    localparam logic [5:0] FN_OR    = 6'b100101;
    localparam logic [5:0] FN_SLT   = 6'b101010;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    typedef enum logic [STATE_W-1:0] {
        StFetch   = STATE_W'(FETCH_ENC),
        StDecode  = STATE_W'(1),
        StMemAdr  = STATE_W'(2),
        StMemRd   = STATE_W'(3),
        StMemWb   = STATE_W'(4),
        StMemWr   = STATE_W'(5),
        StExecute = STATE_W'(6),
        StAluWb   = STATE_W'(7),
        StBranch  = STATE_W'(8),
        StAddiEx  = STATE_W'(9),
        StAddiWb  = STATE_W'(10),
        StJump    = STATE_W'(11)
    } state_t;

    state_t     r_state;
    state_t     w_state_d;
    logic       w_pcwrite;
    logic       w_branch;
    logic       w_take;
    logic [1:0] w_aluop;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= StFetch;
        end else begin
            r_state <= w_state_d;
        end
    end

`ifdef MC_BNE_EN
    localparam logic [5:0] OP_BNE = 6'b000101;

    logic r_is_bne;

    // Captured in DECODE so BRANCH knows which sense of zero to honour.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_is_bne <= 1'b0;
        end else if (r_state == StDecode) begin
            r_is_bne <= (op == OP_BNE);
        end
    end

    assign w_take = zero ^ r_is_bne;
`else
    assign w_take = zero;
`endif

    // Next-state logic
    always_comb begin
        w_state_d = StFetch;
        unique case (r_state)
            StFetch: w_state_d = StDecode;
            StDecode: begin
                unique case (op)
                    OP_LW, OP_SW: w_state_d = StMemAdr;
                    OP_RTYPE:     w_state_d = StExecute;
                    OP_BEQ:       w_state_d = StBranch;
                    OP_ADDI:      w_state_d = StAddiEx;
                    OP_J:         w_state_d = StJump;
`ifdef MC_BNE_EN
                    OP_BNE:       w_state_d = StBranch;
`endif
                    default:      w_state_d = StFetch;
                endcase
            end
            StMemAdr: begin
                if (op == OP_LW) begin
                    w_state_d = StMemRd;
                end else if (op == OP_SW) begin
                    w_state_d = StMemWr;
                end else begin
                    w_state_d = StFetch;
                end
            end
            StMemRd:   w_state_d = StMemWb;
            StExecute: w_state_d = StAluWb;
            StAddiEx:  w_state_d = StAddiWb;
            default:   w_state_d = StFetch;
        endcase
    end

    // Per-state datapath controls; anything not set in a state stays inactive.
    always_comb begin
        w_pcwrite  = 1'b0;
        w_branch   = 1'b0;
        w_aluop    = ALUOP_ADD;
        memwrite   = 1'b0;
        irwrite    = 1'b0;
        regwrite   = 1'b0;
        iord       = 1'b0;
        memtoreg   = 1'b0;
        regdst     = 1'b0;
        alusrca    = 1'b0;
        alusrcb    = 2'b00;
        pcsrc      = 2'b00;
        instr_done = 1'b0;
        unique case (r_state)
            StFetch: begin
                irwrite   = 1'b1;
                w_pcwrite = 1'b1;
                alusrcb   = 2'b01;
            end
            StDecode: begin
                alusrcb = 2'b11;
            end
            StMemAdr: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
            end
            StMemRd: begin
                iord = 1'b1;
            end
            StMemWb: begin
                regwrite   = 1'b1;
                memtoreg   = 1'b1;
                instr_done = 1'b1;
            end
            StMemWr: begin
                iord       = 1'b1;
                memwrite   = 1'b1;
                instr_done = 1'b1;
            end
            StExecute: begin
                alusrca = 1'b1;
                w_aluop = ALUOP_FUNCT;
            end
            StAluWb: begin
                regwrite   = 1'b1;
                regdst     = 1'b1;
                instr_done = 1'b1;
            end
            StBranch: begin
                alusrca    = 1'b1;
                w_aluop    = ALUOP_SUB;
                pcsrc      = 2'b01;
                w_branch   = 1'b1;
                instr_done = 1'b1;
            end
            StAddiEx: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
            end
            StAddiWb: begin
                regwrite   = 1'b1;
                instr_done = 1'b1;
            end
            StJump: begin
                pcsrc      = 2'b10;
                w_pcwrite  = 1'b1;
                instr_done = 1'b1;
            end
            default: begin
                w_aluop = ALUOP_ADD;
            end
        endcase
    end

    // ALU decoder
    always_comb begin
        alucontrol = 3'b010;
        unique case (w_aluop)
            ALUOP_ADD: alucontrol = 3'b010;
            ALUOP_SUB: alucontrol = 3'b110;
            ALUOP_FUNCT: begin
                unique case (funct)
                    FN_ADD:  alucontrol = 3'b010;
                    FN_SUB:  alucontrol = 3'b110;
                    FN_AND:  alucontrol = 3'b000;
                    FN_OR:   alucontrol = 3'b001;
                    FN_SLT:  alucontrol = 3'b111;
                    default: alucontrol = 3'b010;
                endcase
            end
            default: alucontrol = 3'b010;
        endcase
    end

    // PC must not advance while reset is held, even though FETCH requests it.
    assign pcen  = reset & (w_pcwrite | (w_branch & w_take));
    assign state = r_state;

endmodule
